// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI responder (spi_slv16).
//   spi_slv_state_t : frame FSM states (IDLE between frames, SHIFT while selected)
//   SPI_FRAME_W     : default frame width in bits
//   SPI_SYNC_STAGES : flop depth of the SCLK / SS_n synchronisers
package spi_pkg;

  typedef enum logic {IDLE, SHIFT} spi_slv_state_t;

  localparam int SPI_FRAME_W     = 16;
  localparam int SPI_SYNC_STAGES = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser with edge detection for one asynchronous input pin.
// The pin passes through SPI_SYNC_STAGES flops. Edges are detected between the
// last two stages, so rise/fall are glitch-free single-clk pulses.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   rise, fall : one-clk pulses on a synchronised 0->1 / 1->0 transition
// Parameter RST_VAL: value every stage takes in reset (idle level of the pin).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;

  // NOTE: flops use non-blocking assignment so every stage samples the value
  // its predecessor held before this edge; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
    else        sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
  end

  assign rise =  sync_q[SPI_SYNC_STAGES-2] & ~sync_q[SPI_SYNC_STAGES-1];
  assign fall = ~sync_q[SPI_SYNC_STAGES-2] &  sync_q[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slv16.sv
// SPI responder (mode 3, MSB first) with oversampled pins in the clk domain.
// Captures a frame from MOSI while SS_n is low, returns the buffered response
// word on MISO and presents the received word on cmd with a sticky cmd_rdy.
// Ports:
//   clk, rst_n   : system clock (>= 8x SCLK), asynchronous active-low reset
//   SS_n, SCLK   : asynchronous slave select (active low) and SPI clock (idle high)
//   MOSI, MISO   : serial data in / out (MISO tri-stated while deselected)
//   resp         : response word, loaded into the buffer when wrt_resp=1
//   cmd, cmd_rdy : last complete frame and its sticky ready flag
//   clr_cmd_rdy  : clears cmd_rdy (a simultaneous latch wins)
//   frame_err    : only with SPI_SLV_FRAME_ERR_EN defined; sticky flag for a
//                  wrong-length frame or a latch while cmd_rdy was still set
module spi_slv16
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_FRAME_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] resp,
  input  logic              wrt_resp,
  output logic [DATA_W-1:0] cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy
`ifdef SPI_SLV_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(DATA_W);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [1:0] mosi_q;
  logic mosi_sync;
  logic ss_low;

  spi_slv_state_t state, state_nxt;
  logic [DATA_W-1:0] shft, shft_nxt, resp_buf;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic              miso_q, miso_nxt, latch;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SS_n),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // MOSI needs one stage less than SCLK: it is stable long before the
  // synchronised rising edge that samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= 2'b00;
    else        mosi_q <= {mosi_q[0], MOSI};
  end
  assign mosi_sync = mosi_q[1];

  // Synchronised select level, rebuilt from the edge pulses (tracks the last
  // synchroniser stage); used only to enable the MISO driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ss_low <= 1'b0;
    else if (ss_fall) ss_low <= 1'b1;
    else if (ss_rise) ss_low <= 1'b0;
  end

  assign MISO = ss_low ? miso_q : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    shft_nxt  = shft;
    cnt_nxt   = bit_cnt;
    miso_nxt  = miso_q;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          shft_nxt  = resp_buf;
          miso_nxt  = resp_buf[DATA_W-1];
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shft_nxt = {shft[DATA_W-2:0], mosi_sync};
          if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
        end else if (sclk_fall) begin
          miso_nxt = shft[DATA_W-1];
        end
        // End-of-frame decisions look at the post-shift values so a final
        // SCLK rise coinciding with deselect is still counted and captured.
        if (ss_rise) begin
          state_nxt = IDLE;
          latch     = (cnt_nxt >= FRAME_CNT);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft     <= '0;
      bit_cnt  <= '0;
      miso_q   <= 1'b0;
      resp_buf <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      shft    <= shft_nxt;
      bit_cnt <= cnt_nxt;
      miso_q  <= miso_nxt;
      // The frame in progress already holds its copy in shft, so a write
      // here only affects the next frame.
      if (wrt_resp) resp_buf <= resp;
      if (latch)    cmd      <= shft_nxt;
      if (latch)            cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic ferr_set;
  assign ferr_set = (state == SHIFT) && ss_rise &&
                    ((cnt_nxt != FRAME_CNT) || (latch && cmd_rdy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           frame_err <= 1'b0;
    else if (ferr_set)    frame_err <= 1'b1;
    else if (clr_cmd_rdy) frame_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_slv16.sv
// Self-checking bench for spi_slv16: a bit-level SPI master drives frames at
// SCLK = clk/32; a reference model predicts MISO words, latched commands and
// flags; a monitor compares cmd against a queue of expected latches.
module tb_spi_slv16;

  localparam int W    = 16;
  localparam int HALF = 16;  // clk cycles per SCLK half period

  logic          clk = 1'b0;
  logic          rst_n, ss_n, sclk, mosi, wrt_resp, clr_cmd_rdy;
  logic [W-1:0]  resp;
  wire           miso;
  logic [W-1:0]  cmd;
  logic          cmd_rdy;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic          frame_err;
`endif

  spi_slv16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SS_n       (ss_n),
    .SCLK       (sclk),
    .MOSI       (mosi),
    .MISO       (miso),
    .resp       (resp),
    .wrt_resp   (wrt_resp),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy)
`ifdef SPI_SLV_FRAME_ERR_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [W-1:0] exp_cmd_q[$];
  logic [W-1:0] model_resp, model_cmd;
  logic         model_rdy, model_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a latch shows up as cmd_rdy rising, or cmd changing while set.
  initial begin
    logic         prev_rdy;
    logic [W-1:0] prev_cmd;
    logic [W-1:0] e;
    prev_rdy = 1'b0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_rdy && (!prev_rdy || cmd != prev_cmd)) begin
        if (exp_cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_latch: got cmd %h with no frame expected", cmd);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd", {16'h0, cmd}, {16'h0, e});
        end
      end
      prev_rdy = rst_n ? cmd_rdy : 1'b0;
      prev_cmd = rst_n ? cmd : '0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic write_resp(input logic [W-1:0] v);
    @(negedge clk);
    resp = v;
    wrt_resp = 1'b1;
    @(negedge clk);
    wrt_resp = 1'b0;
    model_resp = v;
  endtask

  task automatic clear_rdy();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    model_rdy  = 1'b0;
    model_ferr = 1'b0;
  endtask

  // Sends n bits (bits[n-1] first). Optionally rewrites the response buffer
  // after bit wr_at, and optionally pulses clr_cmd_rdy on the latch clk.
  task automatic spi_frame(input logic [31:0] bits, input int n, input int wr_at,
                           input logic [W-1:0] wr_val, input bit clr_tie);
    logic [W-1:0] exp_miso, rd;
    logic         latched, was_rdy, ferr_set;
    exp_miso = model_resp;
    rd = '0;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = bits[n-1-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      if (i < W) rd = {rd[W-2:0], miso};
      if (i == wr_at) begin
        resp = wr_val;
        wrt_resp = 1'b1;
        @(negedge clk);
        wrt_resp = 1'b0;
        model_resp = wr_val;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (n >= W) check("miso_word", {16'h0, rd}, {16'h0, exp_miso});

    latched  = (n >= W);
    was_rdy  = model_rdy;
    ferr_set = (n != W) || (latched && was_rdy);
    if (latched) exp_cmd_q.push_back(bits[W-1:0]);

    ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (latched && !was_rdy) check("rdy_not_early", {31'h0, cmd_rdy}, 32'h0);
    if (clr_tie) clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;

    if (latched) begin
      model_rdy = 1'b1;
      model_cmd = bits[W-1:0];
    end else if (clr_tie) begin
      model_rdy = 1'b0;
    end
    if (ferr_set)     model_ferr = 1'b1;
    else if (clr_tie) model_ferr = 1'b0;

    check("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, model_rdy});
    check("cmd_hold", {16'h0, cmd}, {16'h0, model_cmd});
`ifdef SPI_SLV_FRAME_ERR_EN
    check("frame_err", {31'h0, frame_err}, {31'h0, model_ferr});
`endif
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] r;
    rst_n = 1'b0;
    ss_n = 1'b1;
    sclk = 1'b1;
    mosi = 1'b0;
    wrt_resp = 1'b0;
    clr_cmd_rdy = 1'b0;
    resp = '0;
    model_resp = '0;
    model_cmd = '0;
    model_rdy = 1'b0;
    model_ferr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic exchange.
    write_resp(16'hA55A);
    spi_frame(32'h1234, 16, -1, '0, 1'b0);
    clear_rdy();

    // Aborted frame after 9 rises: nothing latched.
    spi_frame(32'h01FF, 9, -1, '0, 1'b0);
    clear_rdy();

    // 17-bit frames: oldest bit dropped.
    spi_frame(32'h1_0000, 17, -1, '0, 1'b0);
    clear_rdy();
    spi_frame({15'h0, 16'h8001, 1'b0}, 17, -1, '0, 1'b0);
    clear_rdy();

    // Mid-frame response write affects only the next frame.
    write_resp(16'h0F0F);
    spi_frame(32'h3C3C, 16, 7, 16'hFFFF, 1'b0);
    clear_rdy();
    spi_frame(32'hC3C3, 16, -1, '0, 1'b0);
    clear_rdy();

    // Clear on the latch clk loses; then back-to-back frames overrun.
    spi_frame(32'h5A5A, 16, -1, '0, 1'b1);
    spi_frame(32'h0001, 16, -1, '0, 1'b0);
    spi_frame(32'h0002, 16, -1, '0, 1'b0);
    clear_rdy();

    // Reset in the middle of a frame.
    write_resp(16'h1357);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b0;
      mosi = i[0];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_cmd", {16'h0, cmd}, 32'h0);
    check("midrst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    model_cmd = '0;
    model_rdy = 1'b0;
    model_ferr = 1'b0;
    model_resp = '0;
    ss_n = 1'b1;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_latch", {31'h0, cmd_rdy}, 32'h0);
    write_resp(16'h2468);
    spi_frame(32'hBEEF, 16, -1, '0, 1'b0);
    clear_rdy();

    // Randomised frames.
    for (int k = 0; k < 6; k++) begin
      r = W'($urandom);
      write_resp(r);
      r = W'($urandom);
      spi_frame({16'h0, r}, 16, -1, '0, 1'b0);
      clear_rdy();
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_cmd_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
